yolo_upsamp_2x_stream: RTL and testbench

AXI4-Stream 2x nearest-neighbour upsampler for the Tiny YOLOv3 route path, 13x13 to 26x26. It is the synthesizable kernel that the deadlock monitor watches. It consumes one channel-packed pixel per input beat. Each pixel is emitted twice horizontally, and each row is emitted twice vertically using a one-row line buffer. It also exports the inStream/outStream blk_n signals that the monitor samples.

---
 rtl/yolo_upsamp_2x_stream.sv | 198 +++++++++++++++++++
 tb/tb_yolo_upsamp_2x_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yolo_upsamp_2x_stream.sv
`default_nettype none
// ============================================================================
//  Module      : yolo_upsamp_2x_stream
//  Description : AXI4-Stream 2x nearest-neighbour upsampler (13x13 -> 26x26
//                for the Tiny YOLOv3 route path). Each input pixel is sent
//                twice horizontally (PASS); the row is then replayed from a
//                one-row line buffer (REPLAY) to double it vertically.
//  Ports       : ap_clk/ap_rst        clock, synchronous active-high reset
//                ap_start/done/idle/ready  block-level handshake
//                inStream_*           input pixel stream (TLAST checked)
//                outStream_*          output pixel stream
//                *_TDATA_blk_n        stall indicators for the deadlock monitor
//                err_tlast            sticky input-TLAST mismatch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module yolo_upsamp_2x_stream #(
    parameter int DATA_W = 64,
    parameter int IMG_W  = 13,
    parameter int IMG_H  = 13
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] inStream_TDATA,
    input  logic              inStream_TVALID,
    output logic              inStream_TREADY,
    input  logic              inStream_TLAST,
    output logic [DATA_W-1:0] outStream_TDATA,
    output logic              outStream_TVALID,
    input  logic              outStream_TREADY,
    output logic              outStream_TLAST,
    output logic              inStream_TDATA_blk_n,
    output logic              outStream_TDATA_blk_n,
    output logic              err_tlast
);

    localparam int         c_idx_w    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [5:0] c_last_col = 6'(IMG_W - 1);
    localparam logic [5:0] c_last_row = 6'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PASS   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [5:0]          r_row_q,   w_row_d;
    logic [5:0]          r_col_q,   w_col_d;
    logic                r_ph_q,    w_ph_d;
    logic                r_hv_q,    w_hv_d;
    logic [DATA_W-1:0]   r_hd_q,    w_hd_d;
    logic                r_err_q,   w_err_d;
    logic [DATA_W-1:0]   r_lb_q [IMG_W];

    logic                w_in_ready;
    logic                w_in_acc;
    logic                w_out_valid;
    logic                w_out_hs;
    logic                w_col_end;
    logic                w_row_end;
    logic [5:0]          w_wcol;
    logic [c_idx_w-1:0]  w_widx;
    logic                w_in_is_last;

    assign w_col_end = (r_col_q == c_last_col);
    assign w_row_end = (r_row_q == c_last_row);

    // A new pixel may enter only while the holding register is empty or is
    // being drained by its second copy; never on the row's final beat, since
    // the next row must wait until the replay has finished.
    assign w_in_ready = (r_state_q == ST_PASS) &&
                        (!r_hv_q || (r_ph_q && outStream_TREADY && !w_col_end));
    assign w_in_acc   = w_in_ready && inStream_TVALID;

    assign w_out_valid = ((r_state_q == ST_PASS) && r_hv_q) || (r_state_q == ST_REPLAY);
    assign w_out_hs    = w_out_valid && outStream_TREADY;

    // Column of the pixel being accepted: when the holding register is still
    // full, the incoming pixel belongs to the column after the one on output.
    assign w_wcol       = r_hv_q ? (r_col_q + 6'd1) : r_col_q;
    assign w_widx       = w_wcol[c_idx_w-1:0];
    assign w_in_is_last = w_row_end && (w_wcol == c_last_col);

    always_comb begin
        w_state_d = r_state_q;
        w_row_d   = r_row_q;
        w_col_d   = r_col_q;
        w_ph_d    = r_ph_q;
        w_hv_d    = r_hv_q;
        w_hd_d    = r_hd_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_d = ST_PASS;
                    w_err_d   = 1'b0;
                    w_row_d   = 6'd0;
                    w_col_d   = 6'd0;
                    w_ph_d    = 1'b0;
                    w_hv_d    = 1'b0;
                end
            end
            ST_PASS: begin
                if (w_in_acc) begin
                    w_hd_d = inStream_TDATA;
                    if (inStream_TLAST != w_in_is_last) begin
                        w_err_d = 1'b1;
                    end
                end
                if (w_out_hs) begin
                    if (!r_ph_q) begin
                        w_ph_d = 1'b1;
                    end else begin
                        w_ph_d = 1'b0;
                        w_hv_d = w_in_acc;
                        if (w_col_end) begin
                            w_col_d   = 6'd0;
                            w_state_d = ST_REPLAY;
                        end else begin
                            w_col_d = r_col_q + 6'd1;
                        end
                    end
                end else if (w_in_acc) begin
                    w_hv_d = 1'b1;
                end
            end
            ST_REPLAY: begin
                if (w_out_hs) begin
                    if (!r_ph_q) begin
                        w_ph_d = 1'b1;
                    end else begin
                        w_ph_d = 1'b0;
                        if (w_col_end) begin
                            w_col_d   = 6'd0;
                            w_row_d   = r_row_q + 6'd1;
                            w_state_d = w_row_end ? ST_DONE : ST_PASS;
                        end else begin
                            w_col_d = r_col_q + 6'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_q <= ST_IDLE;
            r_row_q   <= 6'd0;
            r_col_q   <= 6'd0;
            r_ph_q    <= 1'b0;
            r_hv_q    <= 1'b0;
            r_hd_q    <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_row_q   <= w_row_d;
            r_col_q   <= w_col_d;
            r_ph_q    <= w_ph_d;
            r_hv_q    <= w_hv_d;
            r_hd_q    <= w_hd_d;
            r_err_q   <= w_err_d;
        end
    end

    // Line buffer contents are irrelevant after reset, so it carries none.
    always_ff @(posedge ap_clk) begin
        if (w_in_acc) begin
            r_lb_q[w_widx] <= inStream_TDATA;
        end
    end

    assign ap_idle  = (r_state_q == ST_IDLE);
    assign ap_done  = (r_state_q == ST_DONE);
    assign ap_ready = ap_done;

    assign inStream_TREADY  = w_in_ready;
    assign outStream_TVALID = w_out_valid;
    assign outStream_TDATA  = (r_state_q == ST_REPLAY) ? r_lb_q[r_col_q[c_idx_w-1:0]] : r_hd_q;
    assign outStream_TLAST  = (r_state_q == ST_REPLAY) && w_row_end && w_col_end && r_ph_q;

    assign inStream_TDATA_blk_n  = !((r_state_q == ST_PASS) && w_in_ready && !inStream_TVALID);
    assign outStream_TDATA_blk_n = !(w_out_valid && !outStream_TREADY);
    assign err_tlast             = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_yolo_upsamp_2x_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_yolo_upsamp_2x_stream
//  Description : Directed self-checking bench for yolo_upsamp_2x_stream.
//                A 2x2 instance covers the basic frame, backpressure, input
//                starvation, TLAST error and mid-frame reset; a default 13x13
//                instance covers back-to-back ramp frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_yolo_upsamp_2x_stream;

    localparam logic [63:0] c_exp_small [16] = '{
        64'd1, 64'd1, 64'd2, 64'd2, 64'd1, 64'd1, 64'd2, 64'd2,
        64'd3, 64'd3, 64'd4, 64'd4, 64'd3, 64'd3, 64'd4, 64'd4
    };

    logic        clk = 1'b0;
    logic        rst;

    logic        s_start, s_done, s_idle, s_apready;
    logic [63:0] s_idata, s_odata;
    logic        s_ivalid, s_iready, s_ilast;
    logic        s_ovalid, s_oready, s_olast;
    logic        s_iblk, s_oblk, s_err;

    logic        d_start, d_done, d_idle, d_apready;
    logic [63:0] d_idata, d_odata;
    logic        d_ivalid, d_iready, d_ilast;
    logic        d_ovalid, d_oready, d_olast;
    logic        d_iblk, d_oblk, d_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    yolo_upsamp_2x_stream #(.DATA_W(64), .IMG_W(2), .IMG_H(2)) dut_s (
        .ap_clk(clk), .ap_rst(rst), .ap_start(s_start), .ap_done(s_done),
        .ap_idle(s_idle), .ap_ready(s_apready),
        .inStream_TDATA(s_idata), .inStream_TVALID(s_ivalid),
        .inStream_TREADY(s_iready), .inStream_TLAST(s_ilast),
        .outStream_TDATA(s_odata), .outStream_TVALID(s_ovalid),
        .outStream_TREADY(s_oready), .outStream_TLAST(s_olast),
        .inStream_TDATA_blk_n(s_iblk), .outStream_TDATA_blk_n(s_oblk),
        .err_tlast(s_err)
    );

    yolo_upsamp_2x_stream dut_d (
        .ap_clk(clk), .ap_rst(rst), .ap_start(d_start), .ap_done(d_done),
        .ap_idle(d_idle), .ap_ready(d_apready),
        .inStream_TDATA(d_idata), .inStream_TVALID(d_ivalid),
        .inStream_TREADY(d_iready), .inStream_TLAST(d_ilast),
        .outStream_TDATA(d_odata), .outStream_TVALID(d_ovalid),
        .outStream_TREADY(d_oready), .outStream_TLAST(d_olast),
        .inStream_TDATA_blk_n(d_iblk), .outStream_TDATA_blk_n(d_oblk),
        .err_tlast(d_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One 2x2 frame of pixels 1..4. rmode 1 toggles TREADY 1,0,1,0...;
    // starve_px withholds TVALID for 5 ready cycles before that pixel;
    // tlast_px is the pixel carrying TLAST. Called on a falling edge.
    task automatic run_small(input string nm, input int rmode, input int starve_px,
                             input int tlast_px);
        int pi = 0, cyc = 0, nb = 0;
        int last_hs = -1, done_cyc = -1, err_rise = -1, acc_tl = -1, err_drop = 0;
        int starve = 0, inblk0 = 0, outblk_bad = 0, stalls = 0, unstable = 0;
        int tl_cnt = 0, tl_pos = -1, rdy_bad = 0;
        logic [63:0] held = '0;
        bit was_stall = 1'b0;

        @(negedge clk);
        s_start = 1'b1; s_ivalid = 1'b0; s_oready = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        while (cyc < 400 && done_cyc < 0) begin
            s_oready = (rmode == 1) ? (cyc % 2 == 0) : 1'b1;
            s_ivalid = 1'b0; s_ilast = 1'b0; s_idata = '0;
            if (pi < 4) begin
                s_idata  = 64'(pi + 1);
                s_ilast  = (pi == tlast_px);
                s_ivalid = !(pi == starve_px && starve < 5);
            end
            #1;
            if (!s_ivalid && pi == starve_px && starve < 5 && s_iready) starve++;
            if (!s_iblk) inblk0++;
            if (s_oblk != !(s_ovalid && !s_oready)) outblk_bad++;
            if (s_done != s_apready) rdy_bad++;
            if (was_stall && (!s_ovalid || s_odata !== held)) unstable++;
            was_stall = s_ovalid && !s_oready;
            held      = s_odata;
            if (was_stall) stalls++;
            if (s_err && err_rise < 0) err_rise = cyc;
            if (!s_err && err_rise >= 0) err_drop++;
            if (s_done) done_cyc = cyc;
            if (s_ovalid && s_oready) begin
                if (nb < 16) chk($sformatf("%s_beat%0d", nm, nb), s_odata, c_exp_small[nb]);
                if (s_olast) begin tl_cnt++; tl_pos = nb; end
                last_hs = cyc;
                nb++;
            end
            if (s_ivalid && s_iready) begin
                if (pi == tlast_px) acc_tl = cyc;
                pi++;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        chk({nm, "_done_seen"},  64'(done_cyc >= 0), 64'd1);
        chk({nm, "_nbeats"},     64'(nb), 64'd16);
        chk({nm, "_tlast_cnt"},  64'(tl_cnt), 64'd1);
        chk({nm, "_tlast_pos"},  64'(tl_pos), 64'd15);
        chk({nm, "_done_lat"},   64'(done_cyc), 64'(last_hs + 1));
        chk({nm, "_done_pulse"}, {63'd0, s_done}, 64'd0);
        chk({nm, "_idle_after"}, {63'd0, s_idle}, 64'd1);
        chk({nm, "_ready_eq"},   64'(rdy_bad), 64'd0);
        chk({nm, "_outblk"},     64'(outblk_bad), 64'd0);
        chk({nm, "_stable"},     64'(unstable), 64'd0);
        chk({nm, "_inblk0"},     64'(inblk0), (starve_px >= 0) ? 64'd5 : 64'd0);
        chk({nm, "_err"},        {63'd0, s_err}, (tlast_px == 3) ? 64'd0 : 64'd1);
        chk({nm, "_err_rise"},   64'(err_rise), (tlast_px == 3) ? 64'(-1) : 64'(acc_tl + 1));
        chk({nm, "_err_sticky"}, 64'(err_drop), 64'd0);
        if (rmode == 1) chk({nm, "_stalls_seen"}, 64'(stalls > 0), 64'd1);
    endtask

    task automatic run_reset_test();
        int pi = 0, cyc = 0, nb = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        while (nb < 5 && cyc < 100) begin
            s_oready = 1'b1;
            s_ivalid = (pi < 4);
            s_idata  = 64'(pi + 1);
            s_ilast  = (pi == 3);
            #1;
            if (s_ovalid && s_oready) nb++;
            if (s_ivalid && s_iready) pi++;
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("rst_in_replay", {63'd0, s_ovalid}, 64'd1);
        rst = 1'b1; s_ivalid = 1'b0; s_oready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ovalid", {63'd0, s_ovalid}, 64'd0);
        chk("rst_iready", {63'd0, s_iready}, 64'd0);
        chk("rst_olast",  {63'd0, s_olast},  64'd0);
        chk("rst_done",   {63'd0, s_done},   64'd0);
        chk("rst_apready",{63'd0, s_apready},64'd0);
        chk("rst_idle",   {63'd0, s_idle},   64'd1);
        chk("rst_iblk",   {63'd0, s_iblk},   64'd1);
        chk("rst_oblk",   {63'd0, s_oblk},   64'd1);
        chk("rst_err",    {63'd0, s_err},    64'd0);
    endtask

    task automatic run_big();
        int r, c;
        for (int f = 0; f < 2; f++) begin
            int nb = 0, bad = 0, tl = 0, tlp = -1, pi = 0, cyc = 0;
            bit seen = 1'b0;
            chk($sformatf("big%0d_idle_at_start", f), {63'd0, d_idle}, 64'd1);
            d_start = 1'b1;
            @(negedge clk);
            d_start = 1'b0;
            while (!seen && cyc < 4000) begin
                d_oready = 1'b1;
                d_ivalid = (pi < 169);
                d_idata  = 64'(pi);
                d_ilast  = (pi == 168);
                #1;
                if (d_ovalid && d_oready) begin
                    r = nb / 26;
                    c = nb % 26;
                    if (d_odata !== 64'((r / 2) * 13 + c / 2)) bad++;
                    if (d_olast) begin tl++; tlp = nb; end
                    nb++;
                end
                if (d_ivalid && d_iready) pi++;
                if (d_done) seen = 1'b1;
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("big%0d_done_seen", f), {63'd0, seen}, 64'd1);
            chk($sformatf("big%0d_nbeats", f),   64'(nb),  64'd676);
            chk($sformatf("big%0d_badbeats", f), 64'(bad), 64'd0);
            chk($sformatf("big%0d_tlast_cnt", f),64'(tl),  64'd1);
            chk($sformatf("big%0d_tlast_pos", f),64'(tlp), 64'd675);
            chk($sformatf("big%0d_err", f),      {63'd0, d_err}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_start = 1'b0; s_idata = '0; s_ivalid = 1'b0; s_ilast = 1'b0; s_oready = 1'b0;
        d_start = 1'b0; d_idata = '0; d_ivalid = 1'b0; d_ilast = 1'b0; d_oready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_idle",    {63'd0, s_idle},    64'd1);
        chk("reset_done",    {63'd0, s_done},    64'd0);
        chk("reset_apready", {63'd0, s_apready}, 64'd0);
        chk("reset_ovalid",  {63'd0, s_ovalid},  64'd0);
        chk("reset_iready",  {63'd0, s_iready},  64'd0);
        chk("reset_olast",   {63'd0, s_olast},   64'd0);
        chk("reset_iblk",    {63'd0, s_iblk},    64'd1);
        chk("reset_oblk",    {63'd0, s_oblk},    64'd1);
        chk("reset_err",     {63'd0, s_err},     64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_small("basic",   0, -1, 3);
        run_small("bpress",  1, -1, 3);
        run_small("starve",  0,  2, 3);
        run_small("tlasterr",0, -1, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("err_held_idle", {63'd0, s_err}, 64'd1);
        run_small("clear",   0, -1, 3);
        run_reset_test();
        run_small("postrst", 0, -1, 3);
        @(negedge clk);
        run_big();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
